// File: rtl/ram_dumper_pkg.sv
// rtl/ram_dumper_pkg.sv - shared state encoding and frame constants for the RAM dump engine
package ram_dumper_pkg;

  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 4;

`ifdef RAM_DUMPER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_SEND} state_t;
`endif

endpackage

// File: rtl/ram_dumper_tx.sv
// rtl/ram_dumper_tx.sv - 8N1 byte transmitter (uart_tx_byte) with bit-rate counter
// A load while a frame is on the line restarts the frame, so back-to-back bytes load on the done cycle.
module uart_tx_byte
  import ram_dumper_pkg::*;
#(
  parameter int BIT_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [FRAME_BITS-1:0] sh;
  logic [DW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic                  active;
  logic                  bit_end;

  // The line is always the low bit of the shift register; all-ones is idle.
  assign txd     = sh[0];
  assign bit_end = (div_cnt == DW'(BIT_DIV - 1));
  assign done    = active && bit_end && (bit_cnt == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '1;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (load) begin
      sh      <= {1'b1, data, 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        div_cnt <= '0;
        sh      <= {1'b1, sh[FRAME_BITS-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'(FRAME_BITS - 1))
          active <= 1'b0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - serial read-back of the program RAM over an 8N1 TX line
// Optional trailing checksum frame: RAM_DUMPER_CHECKSUM_EN.
module ram_dumper
  import ram_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int BIT_DIV    = 2604
) (
  input  logic                  HCLK,
  input  logic                  resetHW,
  input  logic                  dumpStart,
  input  logic [ADDR_WIDTH-3:0] nWords,
  output logic                  rEn,
  output logic [ADDR_WIDTH-3:0] rAddr,
  input  logic [31:0]           rData,
  output logic                  serialTx,
  output logic                  busy,
  output logic [11:0]           status
);

  localparam int         WA        = ADDR_WIDTH - 2;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t        state;
  logic [WA-1:0] count_q;
  logic [31:0]   shw;
  logic [1:0]    byte_cnt;
  logic          tx_load;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          last_word;
`ifdef RAM_DUMPER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // A latched count of 0 wraps to all-ones here, giving a full 2^WA-word dump.
  assign last_word = (rAddr == (count_q - WA'(1)));
  assign status    = 12'(rAddr);

  always_comb begin
    tx_load = 1'b0;
    tx_data = shw[7:0];
    case (state)
      S_WAIT: begin
        tx_load = 1'b1;
        tx_data = rData[7:0];
      end
      S_SEND: begin
        if (tx_done && byte_cnt != LAST_BYTE)
          tx_load = 1'b1;
`ifdef RAM_DUMPER_CHECKSUM_EN
        if (tx_done && byte_cnt == LAST_BYTE && last_word) begin
          tx_load = 1'b1;
          tx_data = csum;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge resetHW) begin
    if (resetHW) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      rEn      <= 1'b0;
      rAddr    <= '0;
      count_q  <= '0;
      shw      <= '0;
      byte_cnt <= '0;
`ifdef RAM_DUMPER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (dumpStart) begin
            count_q <= nWords;
            rAddr   <= '0;
            busy    <= 1'b1;
            rEn     <= 1'b1;
            state   <= S_READ;
`ifdef RAM_DUMPER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        S_READ: begin
          rEn   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          shw      <= {8'h00, rData[31:8]};
          byte_cnt <= '0;
          state    <= S_SEND;
`ifdef RAM_DUMPER_CHECKSUM_EN
          csum     <= csum + rData[7:0];
`endif
        end
        S_SEND: begin
          if (tx_done) begin
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 2'd1;
              shw      <= shw >> 8;
`ifdef RAM_DUMPER_CHECKSUM_EN
              csum     <= csum + shw[7:0];
`endif
            end else if (last_word) begin
`ifdef RAM_DUMPER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              rAddr <= rAddr + WA'(1);
              rEn   <= 1'b1;
              state <= S_READ;
            end
          end
        end
`ifdef RAM_DUMPER_CHECKSUM_EN
        S_CSUM: begin
          if (tx_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.BIT_DIV(BIT_DIV)) u_tx (
    .clk  (HCLK),
    .rst  (resetHW),
    .load (tx_load),
    .data (tx_data),
    .txd  (serialTx),
    .done (tx_done)
  );

endmodule
